multi_lane_game: RTL and testbench

MULTI_LANE_GAME -- requirements
Module: multi_lane_game

---
 rtl/multi_lane_game.sv | 192 +++++++++++++++++++
 tb/tb_multi_lane_game.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_game.sv
// multi_lane_game: a multi-lane rhythm game core. Chart rows scroll down
// per-lane tracks toward the hit cell (cell 0); button edges on an occupied
// hit cell score points and build a combo, and notes leaving cell 0 are misses.
//
// Chart interface: a pull strobe without back-pressure. chart_rd is high for
// exactly one cycle on each scroll step that still has chart rows left, and
// note_in is sampled on the rising edge that ends that cycle. The chart source
// must present the next row whenever chart_rd can be high. Nothing is consumed
// in any other cycle.
module multi_lane_game #(
    parameter int  LANES    = 2,
    parameter int  DEPTH    = 10,
    parameter int  TICK_DIV = 4,
    parameter int  SONG_LEN = 64,
    parameter int  SCORE_W  = 16,
    localparam int PHASE_W  = $clog2(TICK_DIV)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       btn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LANES-1:0]       note_in,
    output logic [1:0]             state,
    output logic [LANES*DEPTH-1:0] lanes,
    output logic [PHASE_W-1:0]     phase,
    output logic                   chart_rd,
    output logic [LANES-1:0]       hit,
    output logic [LANES-1:0]       miss,
    output logic [SCORE_W-1:0]     score,
    output logic [7:0]             combo,
    output logic [7:0]             max_combo,
    output logic                   finish
);

    localparam int                 STEP_W     = $clog2(SONG_LEN + 1);
    localparam logic [STEP_W-1:0]  SONG_END   = STEP_W'(SONG_LEN);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(TICK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(TICK_DIV / 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                   st, st_nxt;
    logic [LANES-1:0]         btn_q;
    logic                     start_q;
    logic [LANES*DEPTH-1:0]   lanes_q, lanes_nxt;
    logic [PHASE_W-1:0]       phase_q, phase_nxt;
    logic [STEP_W-1:0]        step_q, step_nxt;
    logic [SCORE_W-1:0]       score_q, score_nxt;
    logic [7:0]               combo_q, combo_nxt;
    logic [7:0]               max_q, max_nxt;

    logic [LANES-1:0]         btn_edge;
    logic                     start_edge;
    logic                     scroll;
    logic [DEPTH-1:0]         lane_v;
    int                       hit_cnt;
    int                       pts;
    logic [SCORE_W:0]         score_ext;
    logic [8:0]               combo_ext;

    assign btn_edge   = btn & ~btn_q;
    assign start_edge = start & ~start_q;

    assign state     = st;
    assign lanes     = lanes_q;
    assign phase     = phase_q;
    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_q;

    // State register of the game sequencer.
    always_ff @(posedge clk) begin
        if (!rst) st <= S_IDLE;
        else      st <= st_nxt;
    end

    // Next state, event pulses and the track/score datapath next values.
    always_comb begin
        st_nxt    = st;
        chart_rd  = 1'b0;
        hit       = '0;
        miss      = '0;
        finish    = 1'b0;
        lanes_nxt = lanes_q;
        phase_nxt = phase_q;
        step_nxt  = step_q;
        score_nxt = score_q;
        combo_nxt = combo_q;
        max_nxt   = max_q;
        scroll    = 1'b0;
        lane_v    = '0;
        hit_cnt   = 0;
        pts       = 0;
        score_ext = '0;
        combo_ext = '0;

        case (st)
            S_IDLE: begin
                if (start_edge) begin
                    st_nxt    = S_PLAY;
                    lanes_nxt = '0;
                    phase_nxt = '0;
                    step_nxt  = '0;
                    score_nxt = '0;
                    combo_nxt = '0;
                    max_nxt   = '0;
                end
            end
            S_PLAY: begin
                if (abort) begin
                    // Cancel: drop the track, keep the score for display.
                    st_nxt    = S_IDLE;
                    lanes_nxt = '0;
                    phase_nxt = '0;
                end else if (step_q == SONG_END && lanes_q == '0) begin
                    finish    = 1'b1;
                    st_nxt    = S_RESULT;
                    phase_nxt = '0;
                end else begin
                    scroll    = (phase_q == PHASE_LAST);
                    phase_nxt = scroll ? '0 : phase_q + 1'b1;
                    chart_rd  = scroll && (step_q < SONG_END);
                    for (int i = 0; i < LANES; i++) begin
                        // A hit removes the note before any shift, so it can
                        // never also count as a miss on a scroll cycle.
                        if (btn_edge[i] && lanes_q[i*DEPTH]) begin
                            hit[i]  = 1'b1;
                            hit_cnt = hit_cnt + 1;
                            pts     = pts + ((phase_q < PHASE_HALF) ? 2 : 1);
                        end
                        lane_v = lanes_q[i*DEPTH +: DEPTH] & ~{{(DEPTH-1){1'b0}}, hit[i]};
                        if (scroll) begin
                            miss[i] = lane_v[0];
                            lane_v  = {chart_rd & note_in[i], lane_v[DEPTH-1:1]};
                        end
                        lanes_nxt[i*DEPTH +: DEPTH] = lane_v;
                    end
                    if (chart_rd) step_nxt = step_q + 1'b1;

                    score_ext = {1'b0, score_q} + (SCORE_W+1)'(pts);
                    score_nxt = score_ext[SCORE_W] ? '1 : score_ext[SCORE_W-1:0];

                    // A miss restarts the combo from this cycle's hits.
                    combo_ext = ((|miss) ? 9'd0 : {1'b0, combo_q}) + 9'(hit_cnt);
                    combo_nxt = combo_ext[8] ? 8'hFF : combo_ext[7:0];
                    max_nxt   = (combo_nxt > max_q) ? combo_nxt : max_q;
                end
            end
            S_RESULT: begin
                if (start_edge) st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase

        // No event leaves the block while reset is being applied.
        if (!rst) begin
            chart_rd = 1'b0;
            hit      = '0;
            miss     = '0;
            finish   = 1'b0;
        end
    end

    // Track, timing, scoring and edge-detect registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q   <= '0;
            start_q <= 1'b0;
            lanes_q <= '0;
            phase_q <= '0;
            step_q  <= '0;
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
        end else begin
            btn_q   <= btn;
            start_q <= start;
            lanes_q <= lanes_nxt;
            phase_q <= phase_nxt;
            step_q  <= step_nxt;
            score_q <= score_nxt;
            combo_q <= combo_nxt;
            max_q   <= max_nxt;
        end
    end

endmodule

// File: tb/tb_multi_lane_game.sv
// tb_multi_lane_game: randomized and directed stimulus for multi_lane_game,
// checked every cycle against a note-list reference model of the game rules.
module tb_multi_lane_game;

  localparam int LANES    = 2;
  localparam int DEPTH    = 10;
  localparam int TICK_DIV = 4;
  localparam int SONG_LEN = 160;
  localparam int SCORE_W  = 9;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int LW       = LANES * DEPTH;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [LANES-1:0] btn = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [LANES-1:0] note_in = '0;

  logic [1:0]         state;
  logic [LW-1:0]      lanes;
  logic [PW-1:0]      phase;
  logic               chart_rd, finish;
  logic [LANES-1:0]   hit, miss;
  logic [SCORE_W-1:0] score;
  logic [7:0]         combo, max_combo;

  logic [1:0]         s_state;
  logic [LW-1:0]      s_lanes;
  logic [PW-1:0]      s_phase;
  logic               s_chart_rd, s_finish;
  logic [LANES-1:0]   s_hit, s_miss;
  logic [15:0]        s_score;
  logic [7:0]         s_combo, s_max_combo;

  always #5 clk = ~clk;

  multi_lane_game #(.LANES(LANES), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV),
                    .SONG_LEN(SONG_LEN), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .btn(btn), .start(start), .abort(abort), .note_in(note_in),
    .state(state), .lanes(lanes), .phase(phase), .chart_rd(chart_rd),
    .hit(hit), .miss(miss), .score(score), .combo(combo), .max_combo(max_combo),
    .finish(finish)
  );

  // Short-song instance, shares all inputs; used for the song-length check.
  multi_lane_game #(.LANES(LANES), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV),
                    .SONG_LEN(4), .SCORE_W(16)) dut_s (
    .clk(clk), .rst(rst), .btn(btn), .start(start), .abort(abort), .note_in(note_in),
    .state(s_state), .lanes(s_lanes), .phase(s_phase), .chart_rd(s_chart_rd),
    .hit(s_hit), .miss(s_miss), .score(s_score), .combo(s_combo), .max_combo(s_max_combo),
    .finish(s_finish)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required normal end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Notes are kept as (lane, distance-to-hit-cell) pairs.
  typedef struct packed { int lane; int pos; } note_t;
  note_t notes[$];
  int m_state = 0, m_phase = 0, m_steps = 0, m_score = 0, m_combo = 0, m_max = 0;
  logic [LANES-1:0] m_btn_prev = '0;
  logic m_start_prev = 1'b0;
  bit m_valid = 0;
  logic [LW-1:0] exp_q[$];

  // observed outputs at the latest sample point
  logic [1:0] o_state, o_s_state;
  logic [LW-1:0] o_lanes;
  logic [PW-1:0] o_phase;
  logic o_rd, o_fin, o_s_rd, o_s_fin;
  logic [LANES-1:0] o_hit, o_miss;
  logic [SCORE_W-1:0] o_score;
  logic [7:0] o_combo, o_max;

  function automatic bit has_note(int lane, int p);
    foreach (notes[k]) if (notes[k].lane == lane && notes[k].pos == p) return 1;
    return 0;
  endfunction

  function automatic logic [LW-1:0] lanes_vec();
    logic [LW-1:0] v = '0;
    foreach (notes[k]) v[notes[k].lane*DEPTH + notes[k].pos] = 1'b1;
    return v;
  endfunction

  // One clock: sample and check at the falling edge, advance the model,
  // then return just after the rising edge so inputs can be changed.
  task automatic tick();
    logic [LANES-1:0] edges, e_hit, e_miss;
    bit play, scroll, e_rd, e_fin, st_edge;
    int n_hit, pts;
    note_t tmp[$];
    @(negedge clk);
    play   = (m_state == 1) && rst && !abort;
    edges  = btn & ~m_btn_prev;
    scroll = play && (m_phase == TICK_DIV - 1);
    e_rd   = scroll && (m_steps < SONG_LEN);
    e_fin  = play && (m_steps == SONG_LEN) && (notes.size() == 0);
    e_hit = '0; e_miss = '0;
    for (int l = 0; l < LANES; l++) begin
      e_hit[l]  = play && !e_fin && edges[l] && has_note(l, 0);
      e_miss[l] = scroll && !e_fin && has_note(l, 0) && !e_hit[l];
    end
    o_state = state; o_lanes = lanes; o_phase = phase; o_rd = chart_rd; o_fin = finish;
    o_hit = hit; o_miss = miss; o_score = score; o_combo = combo; o_max = max_combo;
    o_s_state = s_state; o_s_rd = s_chart_rd; o_s_fin = s_finish;
    if (m_valid) begin
      check_eq("state", state, m_state);
      check_eq("lanes", lanes, exp_q.pop_front());
      check_eq("phase", phase, m_phase);
      check_eq("score", score, m_score);
      check_eq("combo", combo, m_combo);
      check_eq("max_combo", max_combo, m_max);
      check_eq("chart_rd", chart_rd, e_rd);
      check_eq("hit", hit, e_hit);
      check_eq("miss", miss, e_miss);
      check_eq("finish", finish, e_fin);
    end
    if (!rst) begin
      notes.delete();
      m_state = 0; m_phase = 0; m_steps = 0; m_score = 0; m_combo = 0; m_max = 0;
      m_btn_prev = '0; m_start_prev = 1'b0; m_valid = 1;
    end else begin
      st_edge = start && !m_start_prev;
      if (m_state == 0) begin
        if (st_edge) begin
          notes.delete();
          m_state = 1; m_phase = 0; m_steps = 0; m_score = 0; m_combo = 0; m_max = 0;
        end
      end else if (m_state == 1) begin
        if (abort) begin
          notes.delete(); m_state = 0; m_phase = 0;
        end else if (e_fin) begin
          m_state = 2; m_phase = 0;
        end else begin
          n_hit = $countones(e_hit);
          pts = n_hit * ((m_phase < TICK_DIV / 2) ? 2 : 1);
          foreach (notes[k]) begin
            note_t n = notes[k];
            if (n.pos == 0 && e_hit[n.lane]) continue;
            if (scroll) begin
              if (n.pos == 0) continue;
              n.pos = n.pos - 1;
            end
            tmp.push_back(n);
          end
          notes = tmp;
          for (int l = 0; l < LANES; l++)
            if (e_rd && note_in[l]) notes.push_back('{lane: l, pos: DEPTH - 1});
          if (e_rd) m_steps++;
          m_phase = (m_phase + 1) % TICK_DIV;
          m_score = (m_score + pts > SCORE_MAX) ? SCORE_MAX : m_score + pts;
          m_combo = (e_miss != 0) ? n_hit : m_combo + n_hit;
          if (m_combo > 255) m_combo = 255;
          if (m_combo > m_max) m_max = m_combo;
        end
      end else begin
        if (st_edge) m_state = 0;
      end
      m_btn_prev = btn;
      m_start_prev = start;
    end
    if (m_valid) exp_q.push_back(lanes_vec());
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_song();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic go_idle();
    if (m_state == 1) begin
      abort = 1'b1; tick(); abort = 1'b0;
    end else if (m_state == 2) begin
      start = 1'b1; tick(); start = 1'b0; tick();
    end
  endtask

  task automatic press_test(input int ph, input int exp_pts, input string tag);
    bit got = 0;
    go_idle();
    start_song();
    for (int c = 0; c < 200 && !got; c++) begin
      note_in = (m_steps == 0) ? 2'b01 : 2'b00;
      btn = (has_note(0, 0) && m_phase == ph) ? 2'b01 : 2'b00;
      tick();
      if (o_hit[0]) got = 1;
    end
    btn = '0; note_in = '0;
    tick();
    check_eq({tag, "_seen"}, got, 1);
    check_eq({tag, "_score"}, o_score, exp_pts);
    check_eq({tag, "_combo"}, o_combo, 1);
  endtask

  // ---------------- stimulus ----------------
  int steps_after, miss_step, n_miss, n_rd, n_fin, n_hits;
  bit loaded, load_chk, got2;
  logic [LANES-1:0] miss_at_hit;

  initial begin
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_eq("reset_state", o_state, 0);
    check_eq("reset_score", o_score, 0);

    // single note, no press: travels to cell 0 and is missed
    start_song();
    loaded = 0; load_chk = 0; steps_after = 0; miss_step = -1; n_miss = 0;
    for (int c = 0; c < 200 && n_miss == 0; c++) begin
      note_in = (m_steps == 0) ? 2'b01 : 2'b00;
      tick();
      if (load_chk) begin check_eq("load_cell9", o_lanes, 20'h00200); load_chk = 0; end
      if (o_rd) begin
        if (!loaded && note_in[0]) begin loaded = 1; load_chk = 1; end
        else if (loaded) steps_after++;
      end
      if (o_miss[0]) begin n_miss++; miss_step = steps_after; end
    end
    note_in = '0;
    tick();
    check_eq("miss_seen", n_miss, 1);
    check_eq("miss_step", miss_step, 10);
    check_eq("miss_combo", o_combo, 0);

    // early and late press timing
    press_test(0, 2, "early");
    press_test(TICK_DIV - 1, 1, "late");

    // both lanes pressed on the scroll cycle
    go_idle(); start_song();
    got2 = 0; miss_at_hit = '1;
    for (int c = 0; c < 200 && !got2; c++) begin
      note_in = (m_steps == 0) ? 2'b11 : 2'b00;
      btn = (has_note(0, 0) && has_note(1, 0) && m_phase == TICK_DIV - 1) ? 2'b11 : 2'b00;
      tick();
      if (o_hit == 2'b11) begin got2 = 1; miss_at_hit = o_miss; end
    end
    btn = '0; note_in = '0;
    tick();
    check_eq("dual_seen", got2, 1);
    check_eq("dual_miss", miss_at_hit, 0);
    check_eq("dual_score", o_score, 2);
    check_eq("dual_combo", o_combo, 2);
    check_eq("dual_lanes", o_lanes, 0);

    // short song on the 4-row instance: all rows empty
    rst = 1'b0; tick(); rst = 1'b1; tick();
    start_song();
    n_rd = 0; n_fin = 0;
    for (int c = 0; c < 100 && o_s_state != 2; c++) begin
      note_in = '0;
      tick();
      n_rd += o_s_rd; n_fin += o_s_fin;
    end
    for (int c = 0; c < 3; c++) begin tick(); n_fin += o_s_fin; end
    check_eq("short_rd", n_rd, 4);
    check_eq("short_fin", n_fin, 1);
    check_eq("short_state", o_s_state, 2);
    start = 1'b1; tick(); start = 1'b0; tick();
    check_eq("short_back_idle", o_s_state, 0);

    // full song, every note hit early: combo and score saturate
    go_idle(); start_song();
    n_hits = 0; n_fin = 0;
    for (int c = 0; c < 2000 && o_state != 2; c++) begin
      note_in = 2'b11;
      for (int l = 0; l < LANES; l++) btn[l] = has_note(l, 0) && (m_phase == 0);
      tick();
      n_hits += $countones(o_hit); n_fin += o_fin;
    end
    note_in = '0; btn = '0;
    check_eq("sat_hits", n_hits, 2 * SONG_LEN);
    check_eq("sat_fin", n_fin, 1);
    check_eq("sat_combo", o_combo, 255);
    check_eq("sat_max", o_max, 255);
    check_eq("sat_score", o_score, SCORE_MAX);
    btn = 2'b11; tick(); btn = '0; tick();
    check_eq("result_frozen", o_score, SCORE_MAX);

    // abort mid-song
    go_idle(); start_song();
    n_fin = 0;
    for (int c = 0; c < 60; c++) begin
      note_in = LANES'($urandom_range(0, 3));
      btn = LANES'($urandom_range(0, 3));
      tick(); n_fin += o_fin;
    end
    abort = 1'b1; tick(); n_fin += o_fin; abort = 1'b0; btn = '0;
    tick();
    check_eq("abort_state", o_state, 0);
    check_eq("abort_lanes", o_lanes, 0);
    check_eq("abort_fin", n_fin, 0);

    // random songs: one plays out, one aborted, one reset mid-play
    for (int song = 0; song < 3; song++) begin
      go_idle(); start_song();
      for (int c = 0; c < 1200; c++) begin
        if (song == 1 && c == 300) begin
          abort = 1'b1; tick(); abort = 1'b0; break;
        end
        if (song == 2 && c == 200) begin
          rst = 1'b0; tick(); rst = 1'b1;
          btn = '0; tick();
          check_eq("rst_state", o_state, 0);
          check_eq("rst_lanes", o_lanes, 0);
          check_eq("rst_phase", o_phase, 0);
          check_eq("rst_score", o_score, 0);
          check_eq("rst_combo", o_combo, 0);
          check_eq("rst_max", o_max, 0);
          check_eq("rst_pulses", {o_rd, o_fin, o_hit, o_miss}, 0);
          break;
        end
        note_in = LANES'($urandom_range(0, 3));
        btn = LANES'($urandom_range(0, 3));
        tick();
        if (o_state == 2) break;
      end
      btn = '0; note_in = '0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
